// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage.
// Control codes, opcodes, decoded-op bundle and buffer states.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        is_branch;
  } alu_op_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I subset decoder feeding the issue buffer.
// Unsupported encodings raise o_illegal and are never enqueued.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output alu_op_t     o_op,
  output logic        o_illegal
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];

  // Map opcode/funct fields to ALU control and operand 2 source
  always_comb begin
    o_op.ctrl      = ALU_ADD;
    o_op.op1       = i_rs1;
    o_op.op2       = i_rs2;
    o_op.rd        = i_instr[11:7];
    o_op.is_branch = 1'b0;
    o_illegal      = 1'b0;
    unique case (w_opc)
      OP_R: begin
        unique case (1'b1)
          (w_f7 == F7_BASE && w_f3 == 3'b000): o_op.ctrl = ALU_ADD;
          (w_f7 == F7_ALT  && w_f3 == 3'b000): o_op.ctrl = ALU_SUB;
          (w_f7 == F7_BASE && w_f3 == 3'b111): o_op.ctrl = ALU_AND;
          (w_f7 == F7_BASE && w_f3 == 3'b110): o_op.ctrl = ALU_OR;
          default: o_illegal = 1'b1;
        endcase
      end
      OP_I: begin
        o_op.op2 = sext12(i_instr[31:20]);
        unique case (w_f3)
          3'b000:  o_op.ctrl = ALU_ADD;
          3'b111:  o_op.ctrl = ALU_AND;
          3'b110:  o_op.ctrl = ALU_OR;
          default: o_illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        o_op.op2  = sext12(i_instr[31:20]);
        o_illegal = (w_f3 != 3'b010);
      end
      OP_SW: begin
        o_op.op2  = sext12({i_instr[31:25], i_instr[11:7]});
        o_op.rd   = 5'd0;
        o_illegal = (w_f3 != 3'b010);
      end
      OP_BEQ: begin
        o_op.ctrl      = ALU_SUB;
        o_op.rd        = 5'd0;
        o_op.is_branch = 1'b1;
        o_illegal      = (w_f3 != 3'b000);
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: decode, 2-entry skid buffer,
// registered ALU inputs and a saturating illegal-instruction counter.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Instr,
  input  logic [31:0]      Rs1Data,
  input  logic [31:0]      Rs2Data,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [3:0]       Control,
  output logic [31:0]      Operand1,
  output logic [31:0]      Operand2,
  output logic [4:0]       Rd,
  output logic             IsBranch,
  output logic [CNT_W-1:0] IllegalCount
);

  buf_state_t       r_state;
  alu_op_t          r_head;
  alu_op_t          r_tail;
  logic [CNT_W-1:0] r_ill_cnt;

  alu_op_t w_dec;
  logic    w_illegal;
  logic    w_take;
  logic    w_push;
  logic    w_pop;
  logic    w_drop;

  alu_decode u_dec (
    .i_instr   (Instr),
    .i_rs1     (Rs1Data),
    .i_rs2     (Rs2Data),
    .o_op      (w_dec),
    .o_illegal (w_illegal)
  );

  assign InReady  = !Reset && (r_state != BUF_TWO);
  assign OutValid = (r_state != BUF_EMPTY);

  assign w_take = InValid && InReady;
  assign w_push = w_take && !w_illegal;
  assign w_drop = w_take && w_illegal;
  assign w_pop  = OutValid && OutReady;

  assign Control  = r_head.ctrl;
  assign Operand1 = r_head.op1;
  assign Operand2 = r_head.op2;
  assign Rd       = r_head.rd;
  assign IsBranch = r_head.is_branch;

  assign IllegalCount = r_ill_cnt;

  // Skid buffer FSM; head doubles as the ALU input register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= BUF_EMPTY;
      r_head  <= '{ctrl: ALU_ADD, op1: '0, op2: '0,
                   rd: '0, is_branch: 1'b0};
      r_tail  <= '{ctrl: ALU_ADD, op1: '0, op2: '0,
                   rd: '0, is_branch: 1'b0};
    end else begin
      unique case (r_state)
        BUF_EMPTY: begin
          if (w_push) begin
            r_head  <= w_dec;
            r_state <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (w_push && w_pop) begin
            r_head <= w_dec;
          end else if (w_push) begin
            r_tail  <= w_dec;
            r_state <= BUF_TWO;
          end else if (w_pop) begin
            // Operands hold; control falls back to a safe ADD
            r_head.ctrl      <= ALU_ADD;
            r_head.is_branch <= 1'b0;
            r_state          <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_state <= BUF_ONE;
          end
        end
        default: r_state <= BUF_EMPTY;
      endcase
    end
  end

  // Count dropped unsupported instructions, sticking at all-ones
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ill_cnt <= '0;
    end else if (w_drop && (r_ill_cnt != {CNT_W{1'b1}})) begin
      r_ill_cnt <= r_ill_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
// Hand-computed expectations for decode, backpressure, saturation, reset.
module tb_alu_issue_stage;

  logic        Clk;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instr;
  logic [31:0] Rs1Data;
  logic [31:0] Rs2Data;
  logic        OutValid;
  logic        OutReady;
  logic [3:0]  Control;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [4:0]  Rd;
  logic        IsBranch;
  logic [7:0]  IllegalCount;

  int checks;
  int failures;

  alu_issue_stage #(.CNT_W(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .InValid      (InValid),
    .InReady      (InReady),
    .Instr        (Instr),
    .Rs1Data      (Rs1Data),
    .Rs2Data      (Rs2Data),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .Control      (Control),
    .Operand1     (Operand1),
    .Operand2     (Operand2),
    .Rd           (Rd),
    .IsBranch     (IsBranch),
    .IllegalCount (IllegalCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins,
                       input logic [31:0] a,
                       input logic [31:0] b);
    InValid = 1'b1;
    Instr   = ins;
    Rs1Data = a;
    Rs2Data = b;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b1;
    Instr    = 32'h0;
    Rs1Data  = 32'h0;
    Rs2Data  = 32'h0;
    #1;
    chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
    chk("rst_inready", {31'd0, InReady}, 32'd0);
    chk("rst_control", {28'd0, Control}, 32'h2);
    chk("rst_op1", Operand1, 32'h0);
    chk("rst_op2", Operand2, 32'h0);
    chk("rst_rd", {27'd0, Rd}, 32'd0);
    chk("rst_br", {31'd0, IsBranch}, 32'd0);
    chk("rst_cnt", {24'd0, IllegalCount}, 32'd0);
    step();
    step();
    Reset = 1'b0;
    #1;
    chk("idle_inready", {31'd0, InReady}, 32'd1);

    drive(32'h002081B3, 32'd5, 32'd7);
    step();
    chk("add_valid", {31'd0, OutValid}, 32'd1);
    chk("add_ctrl", {28'd0, Control}, 32'h2);
    chk("add_op1", Operand1, 32'd5);
    chk("add_op2", Operand2, 32'd7);
    chk("add_rd", {27'd0, Rd}, 32'd3);
    chk("add_br", {31'd0, IsBranch}, 32'd0);

    drive(32'hFFF00093, 32'd0, 32'd9);
    step();
    chk("addi_ctrl", {28'd0, Control}, 32'h2);
    chk("addi_op2", Operand2, 32'hFFFFFFFF);
    chk("addi_rd", {27'd0, Rd}, 32'd1);

    drive(32'h402081B3, 32'd20, 32'd3);
    step();
    chk("sub_ctrl", {28'd0, Control}, 32'h6);
    chk("sub_op1", Operand1, 32'd20);
    chk("sub_op2", Operand2, 32'd3);

    drive(32'h00208063, 32'd4, 32'd4);
    step();
    chk("beq_ctrl", {28'd0, Control}, 32'h6);
    chk("beq_br", {31'd0, IsBranch}, 32'd1);
    chk("beq_rd", {27'd0, Rd}, 32'd0);

    drive(32'hFE20AE23, 32'd100, 32'd11);
    step();
    chk("sw_op2", Operand2, 32'hFFFFFFFC);
    chk("sw_rd", {27'd0, Rd}, 32'd0);
    chk("sw_br", {31'd0, IsBranch}, 32'd0);

    drive(32'h0020F233, 32'hF0F0, 32'h0FF0);
    step();
    chk("and_ctrl", {28'd0, Control}, 32'h0);
    chk("and_rd", {27'd0, Rd}, 32'd4);

    drive(32'h00F0E293, 32'h1234, 32'h9999);
    step();
    chk("ori_ctrl", {28'd0, Control}, 32'h1);
    chk("ori_op2", Operand2, 32'h0000000F);
    chk("ori_rd", {27'd0, Rd}, 32'd5);

    drive(32'h0080A303, 32'h40, 32'h1);
    step();
    chk("lw_ctrl", {28'd0, Control}, 32'h2);
    chk("lw_op2", Operand2, 32'd8);
    chk("lw_rd", {27'd0, Rd}, 32'd6);

    InValid = 1'b0;
    step();
    chk("drain_valid", {31'd0, OutValid}, 32'd0);
    chk("drain_ctrl", {28'd0, Control}, 32'h2);
    chk("drain_op2_hold", Operand2, 32'd8);

    OutReady = 1'b0;
    drive(32'h002081B3, 32'd1, 32'd2);
    step();
    chk("bp1_valid", {31'd0, OutValid}, 32'd1);
    chk("bp1_inready", {31'd0, InReady}, 32'd1);
    drive(32'h402081B3, 32'd10, 32'd3);
    step();
    chk("bp2_inready", {31'd0, InReady}, 32'd0);
    chk("bp2_head_op1", Operand1, 32'd1);
    drive(32'h0020E233, 32'h55, 32'hAA);
    step();
    chk("bp3_inready", {31'd0, InReady}, 32'd0);
    chk("bp3_head_ctrl", {28'd0, Control}, 32'h2);
    chk("bp3_head_op1", Operand1, 32'd1);
    OutReady = 1'b1;
    step();
    chk("rel1_ctrl", {28'd0, Control}, 32'h6);
    chk("rel1_op1", Operand1, 32'd10);
    chk("rel1_inready", {31'd0, InReady}, 32'd1);
    step();
    chk("rel2_ctrl", {28'd0, Control}, 32'h1);
    chk("rel2_op1", Operand1, 32'h55);
    chk("rel2_op2", Operand2, 32'hAA);
    InValid = 1'b0;
    step();
    chk("rel3_valid", {31'd0, OutValid}, 32'd0);

    drive(32'h0020C1B3, 32'd1, 32'd2);
    repeat (10) step();
    chk("ill10_cnt", {24'd0, IllegalCount}, 32'd10);
    chk("ill10_valid", {31'd0, OutValid}, 32'd0);
    repeat (290) step();
    chk("ill_sat_cnt", {24'd0, IllegalCount}, 32'd255);
    chk("ill_valid", {31'd0, OutValid}, 32'd0);
    chk("ill_ctrl", {28'd0, Control}, 32'h2);
    InValid = 1'b0;

    OutReady = 1'b0;
    drive(32'h402081B3, 32'd77, 32'd1);
    step();
    drive(32'h0020F233, 32'd66, 32'd2);
    step();
    InValid = 1'b0;
    chk("pre_rst_valid", {31'd0, OutValid}, 32'd1);
    chk("pre_rst_full", {31'd0, InReady}, 32'd0);
    chk("pre_rst_ctrl", {28'd0, Control}, 32'h6);
    Reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, OutValid}, 32'd0);
    chk("arst_ctrl", {28'd0, Control}, 32'h2);
    chk("arst_cnt", {24'd0, IllegalCount}, 32'd0);
    chk("arst_op1", Operand1, 32'd0);
    step();
    Reset = 1'b0;
    #1;
    chk("post_rst_valid", {31'd0, OutValid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
